boot_sequencer: RTL and testbench

- Sits between the 48 MHz PLL, the USB pins and the bootloader core on the board top level.
- Generates the core reset from PLL lock and watches the synchronised USB line state for host activity.
- Auto-boots the user image after an idle timeout, or on a boot request from the bootloader after a drain delay.
- Drives the SB_WARMBOOT BOOT/S1/S0 inputs.

---
 rtl/boot_sequencer.sv | 145 ++++++++++++++
 tb/tb_boot_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/boot_sequencer.sv
// boot_sequencer: PLL-lock core reset, USB activity detection and SB_WARMBOOT control.
// Define AUTOBOOT_TIMEOUT_EN to enable the RUN_IDLE idle-timeout auto-boot.
module boot_sequencer #(
    parameter int unsigned RESET_CYCLES      = 4800,
    parameter int unsigned TIMEOUT_CYCLES    = 96000000,
    parameter int unsigned BOOT_DELAY_CYCLES = 480000,
    parameter logic [1:0]  BOOT_IMAGE        = 2'b01
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       usb_p_rx,
    input  logic       usb_n_rx,
    input  logic       boot_req,
    output logic       core_reset,
    output logic       warm_boot,
    output logic [1:0] boot_sel,
    output logic       usb_active,
    output logic [2:0] state
);
    localparam int unsigned MAX_AB     = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_AB > BOOT_DELAY_CYCLES) ? MAX_AB : BOOT_DELAY_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] RESET_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(BOOT_DELAY_CYCLES - 1);
`ifdef AUTOBOOT_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        RESET_WAIT = 3'd0,
        RUN_IDLE   = 3'd1,
        RUN_ACTIVE = 3'd2,
        BOOT_DELAY = 3'd3,
        BOOT       = 3'd4
    } state_t;

    state_t        fsm;
    logic [CW-1:0] cnt;
    logic          lock_meta, lock_s;
    logic [1:0]    usb_meta, usb_s, usb_prev;
    logic          activity;

    assign activity = (usb_s != usb_prev);
    assign boot_sel = BOOT_IMAGE;
    assign state    = fsm;

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            lock_meta  <= 1'b0;
            lock_s     <= 1'b0;
            usb_meta   <= '0;
            usb_s      <= '0;
            usb_prev   <= '0;
            cnt        <= '0;
            fsm        <= RESET_WAIT;
            core_reset <= 1'b1;
            warm_boot  <= 1'b0;
            usb_active <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
            usb_meta  <= {usb_p_rx, usb_n_rx};
            usb_s     <= usb_meta;
            usb_prev  <= usb_s;

            case (fsm)
                RESET_WAIT: begin
                    if (!lock_s) begin
                        cnt <= '0;
                    end else if (cnt == RESET_LAST) begin
                        fsm        <= RUN_IDLE;
                        core_reset <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN_IDLE: begin
                    if (!lock_s) begin
                        fsm        <= RESET_WAIT;
                        core_reset <= 1'b1;
                        usb_active <= 1'b0;
                        cnt        <= '0;
                    end else if (boot_req) begin
                        fsm <= BOOT_DELAY;
                        cnt <= '0;
                    end else if (activity) begin
                        fsm        <= RUN_ACTIVE;
                        usb_active <= 1'b1;
                        cnt        <= '0;
`ifdef AUTOBOOT_TIMEOUT_EN
                    end else if (cnt == TIMEOUT_LAST) begin
                        // No host attached, so boot straight away without a drain delay
                        fsm       <= BOOT;
                        warm_boot <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`else
                    end else begin
                        cnt <= '0;
                    end
`endif
                end
                RUN_ACTIVE: begin
                    cnt <= '0;
                    if (!lock_s) begin
                        fsm        <= RESET_WAIT;
                        core_reset <= 1'b1;
                        usb_active <= 1'b0;
                    end else if (boot_req) begin
                        fsm <= BOOT_DELAY;
                    end
                end
                BOOT_DELAY: begin
                    if (!lock_s) begin
                        fsm        <= RESET_WAIT;
                        core_reset <= 1'b1;
                        usb_active <= 1'b0;
                        cnt        <= '0;
                    end else if (cnt == DELAY_LAST) begin
                        fsm       <= BOOT;
                        warm_boot <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BOOT: begin
                    warm_boot <= 1'b1;
                end
                default: begin
                    fsm        <= RESET_WAIT;
                    core_reset <= 1'b1;
                    usb_active <= 1'b0;
                    warm_boot  <= 1'b0;
                    cnt        <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_boot_sequencer.sv
// Testbench for boot_sequencer: table-driven steps checked through an expected-output queue.
module tb_boot_sequencer;
    logic       clk_48mhz = 1'b0;
    logic       reset     = 1'b0;
    logic       pll_lock  = 1'b0;
    logic       usb_p_rx  = 1'b0;
    logic       usb_n_rx  = 1'b0;
    logic       boot_req  = 1'b0;
    logic       core_reset, warm_boot, usb_active;
    logic [1:0] boot_sel;
    logic [2:0] state;

`ifdef AUTOBOOT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic       lock, p, n, breq;
        int         cyc;
        logic       cr, wb, act;
        logic [2:0] st;
    } step_t;

    typedef struct {
        int         id;
        logic       cr, wb, act;
        logic [2:0] st;
    } exp_t;

    step_t tbl[$];
    exp_t  sb[$];
    int    nvec = 0;
    int    nerr = 0;

    boot_sequencer #(
        .RESET_CYCLES(4),
        .TIMEOUT_CYCLES(20),
        .BOOT_DELAY_CYCLES(8),
        .BOOT_IMAGE(2'b01)
    ) dut (
        .clk_48mhz(clk_48mhz),
        .reset(reset),
        .pll_lock(pll_lock),
        .usb_p_rx(usb_p_rx),
        .usb_n_rx(usb_n_rx),
        .boot_req(boot_req),
        .core_reset(core_reset),
        .warm_boot(warm_boot),
        .boot_sel(boot_sel),
        .usb_active(usb_active),
        .state(state)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    task automatic add(input logic lock, input logic p, input logic n, input logic breq,
                       input int cyc, input logic cr, input logic wb, input logic act,
                       input logic [2:0] st);
        step_t s;
        s.lock = lock; s.p = p; s.n = n; s.breq = breq; s.cyc = cyc;
        s.cr = cr; s.wb = wb; s.act = act; s.st = st;
        tbl.push_back(s);
    endtask

    task automatic push(input int id, input logic cr, input logic wb, input logic act,
                        input logic [2:0] st);
        exp_t e;
        e.id = id; e.cr = cr; e.wb = wb; e.act = act; e.st = st;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        nvec++;
        if (sb.size() == 0) begin
            nerr++;
            $display("FAIL scoreboard: nothing expected, got state=%0d", state);
            return;
        end
        e = sb.pop_front();
        if ({core_reset, warm_boot, usb_active, state, boot_sel} !== {e.cr, e.wb, e.act, e.st, 2'b01}) begin
            nerr++;
            $display("FAIL step %0d: got core_reset=%b warm_boot=%b usb_active=%b state=%0d boot_sel=%b; want %b %b %b %0d 01",
                     e.id, core_reset, warm_boot, usb_active, state, boot_sel, e.cr, e.wb, e.act, e.st);
        end
    endtask

    // Asynchronous reset applied between clock edges and checked before the next edge.
    task automatic do_reset(input int id);
        @(negedge clk_48mhz);
        #2;
        reset    = 1'b1;
        pll_lock = 1'b0;
        usb_p_rx = 1'b0;
        usb_n_rx = 1'b0;
        boot_req = 1'b0;
        push(id, 1'b1, 1'b0, 1'b0, 3'd0);
        #1;
        sample();
        @(negedge clk_48mhz);
        reset = 1'b0;
    endtask

    task automatic run(input int first, input int last);
        for (int i = first; i < last; i++) begin
            pll_lock = tbl[i].lock;
            usb_p_rx = tbl[i].p;
            usb_n_rx = tbl[i].n;
            boot_req = tbl[i].breq;
            push(i, tbl[i].cr, tbl[i].wb, tbl[i].act, tbl[i].st);
            repeat (tbl[i].cyc) @(posedge clk_48mhz);
            @(negedge clk_48mhz);
            sample();
        end
    endtask

    initial begin
        int b1, b2, b3;

        // Power-up and idle auto-boot (lines constant {1,0})
        add(0, 1, 0, 0, 5,    1, 0, 0, 3'd0);
        add(1, 1, 0, 0, 5,    1, 0, 0, 3'd0);
        add(1, 1, 0, 0, 1,    0, 0, 0, 3'd1);
        add(1, 1, 0, 0, 19,   0, 0, 0, 3'd1);
        add(1, 1, 0, 0, 1,    0, TO_EN, 0, TO_EN ? 3'd4 : 3'd1);
        add(1, 1, 0, 0, 1000, 0, TO_EN, 0, TO_EN ? 3'd4 : 3'd1);
        add(0, 1, 0, 0, 5,    !TO_EN, TO_EN, 0, TO_EN ? 3'd4 : 3'd0);
        b1 = tbl.size();

        // Lock glitch, then host activity and requested boot
        add(0, 1, 0, 0, 3,    1, 0, 0, 3'd0);
        add(1, 1, 0, 0, 2,    1, 0, 0, 3'd0);
        add(0, 1, 0, 0, 1,    1, 0, 0, 3'd0);
        add(1, 1, 0, 0, 5,    1, 0, 0, 3'd0);
        add(1, 1, 0, 0, 1,    0, 0, 0, 3'd1);
        add(1, 1, 0, 0, 9,    0, 0, 0, 3'd1);
        add(1, 0, 1, 0, 1,    0, 0, 0, 3'd1);
        add(1, 0, 1, 0, 1,    0, 0, 0, 3'd1);
        add(1, 0, 1, 0, 1,    0, 0, 1, 3'd2);
        add(1, 0, 1, 0, 100,  0, 0, 1, 3'd2);
        add(1, 0, 1, 1, 1,    0, 0, 1, 3'd3);
        add(1, 0, 1, 0, 3,    0, 0, 1, 3'd3);
        add(1, 0, 1, 1, 1,    0, 0, 1, 3'd3);
        add(1, 0, 1, 0, 3,    0, 0, 1, 3'd3);
        add(1, 0, 1, 0, 1,    0, 1, 1, 3'd4);
        b2 = tbl.size();

        // Lock loss during BOOT_DELAY, then boot_req on the timeout cycle
        add(0, 1, 0, 0, 3,    1, 0, 0, 3'd0);
        add(1, 1, 0, 0, 6,    0, 0, 0, 3'd1);
        add(1, 0, 1, 0, 5,    0, 0, 1, 3'd2);
        add(1, 0, 1, 1, 1,    0, 0, 1, 3'd3);
        add(1, 0, 1, 0, 3,    0, 0, 1, 3'd3);
        add(0, 0, 1, 0, 1,    0, 0, 1, 3'd3);
        add(0, 0, 1, 0, 1,    0, 0, 1, 3'd3);
        add(0, 0, 1, 0, 1,    1, 0, 0, 3'd0);
        add(0, 0, 1, 0, 20,   1, 0, 0, 3'd0);
        add(1, 0, 1, 0, 6,    0, 0, 0, 3'd1);
        add(1, 0, 1, 0, 19,   0, 0, 0, 3'd1);
        add(1, 0, 1, 1, 1,    0, 0, 0, 3'd3);
        add(1, 0, 1, 0, 8,    0, 1, 0, 3'd4);
        b3 = tbl.size();

        do_reset(-1);
        run(0, b1);
        do_reset(-2);
        run(b1, b2);
        do_reset(-3);
        run(b2, b3);
        do_reset(-4);

        if (sb.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL scoreboard: %0d expected entries left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
